// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned FWD_W = 2;
  localparam int unsigned LAT_W = 2;

  typedef logic [FWD_W-1:0] fwd_sel_t;
  typedef logic [LAT_W-1:0] lat_t;

  localparam fwd_sel_t STG_RF  = 2'd0;
  localparam fwd_sel_t STG_EXE = 2'd1;
  localparam fwd_sel_t STG_MEM = 2'd2;
  localparam fwd_sel_t STG_WB  = 2'd3;

  localparam lat_t LAT_ALU  = 2'd1;
  localparam lat_t LAT_LOAD = 2'd2;
  localparam lat_t LAT_MUL  = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight write record: valid, pipeline age and producer latency.
module sb_entry #(
  parameter int unsigned SW    = 2,
  parameter int unsigned LATW  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            advance,
  input  logic [LATW-1:0] lat_in,
  output logic            valid,
  output logic [SW-1:0]   age,
  output logic [LATW-1:0] lat
);

  // A new issue overrides ageing/retirement so the newest producer always wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      age   <= '0;
      lat   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      age   <= SW'(1);
      lat   <= lat_in;
    end else if (advance && valid) begin
      if (age == SW'(DEPTH - 1)) begin
        valid <= 1'b0;
      end else begin
        age <= age + SW'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: tracks in-flight register writes, selects bypass stages
// for rs/rt and raises a stall when a producer's result is not yet bypassable.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LATW  = LAT_W,
  parameter int unsigned SW    = FWD_W,
  parameter int unsigned CNTW  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 hold,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_wr_en,
  input  logic [AW-1:0]        id_wr_num,
  input  logic [LATW-1:0]      id_lat,
  output logic [SW-1:0]        fwd_rs,
  output logic [SW-1:0]        fwd_rt,
  output logic                 id_stall,
  output logic [(2**AW)-1:0]   busy_mask,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam int unsigned NREG = 2**AW;

  logic                issue;
  logic [NREG-1:0]     valid_v;
  logic [SW-1:0]       age_v [NREG];
  logic [LATW-1:0]     lat_v [NREG];
  logic                stall_rs_c;
  logic                stall_rt_c;

  assign issue = id_valid & id_wr_en & (id_wr_num != '0) & ~id_stall & ~hold;

  // Register 0 is hard-wired and never tracked.
  assign valid_v[0] = 1'b0;
  assign age_v[0]   = '0;
  assign lat_v[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(
      .SW    (SW),
      .LATW  (LATW),
      .DEPTH (DEPTH)
    ) u_entry (
      .clk     (clk),
      .rstn    (rstn),
      .load    (issue && (id_wr_num == AW'(r))),
      .advance (~hold),
      .lat_in  (id_lat),
      .valid   (valid_v[r]),
      .age     (age_v[r]),
      .lat     (lat_v[r])
    );
  end

  // rs read port: bypass from the producer's current stage once its latency has elapsed.
  always_comb begin
    fwd_rs     = SW'(STG_RF);
    stall_rs_c = 1'b0;
    if (id_use_rs && valid_v[id_rs] && (id_rs != '0)) begin
      if (32'(age_v[id_rs]) >= 32'(lat_v[id_rs])) begin
        fwd_rs = age_v[id_rs];
      end else begin
        stall_rs_c = 1'b1;
      end
    end
  end

  // rt read port.
  always_comb begin
    fwd_rt     = SW'(STG_RF);
    stall_rt_c = 1'b0;
    if (id_use_rt && valid_v[id_rt] && (id_rt != '0)) begin
      if (32'(age_v[id_rt]) >= 32'(lat_v[id_rt])) begin
        fwd_rt = age_v[id_rt];
      end else begin
        stall_rt_c = 1'b1;
      end
    end
  end

  assign id_stall  = id_valid & (stall_rs_c | stall_rt_c);
  assign busy_mask = valid_v;

  // Saturating count of cycles lost to operand stalls (frozen while held).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (id_stall && !hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

  // Latencies beyond WB cannot be bypassed and would never become ready.
  a_lat_legal : assert property (@(posedge clk) disable iff (!rstn)
    issue |-> (32'(id_lat) <= 32'(DEPTH - 1)));

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard/forwarding decode. Tracks every in-flight register write with a per-register age and latency scoreboard.
- For each source operand it generates a generalised bypass-stage select and a load/multi-cycle-use stall.
- Handles arbitrary pipeline depth, producer latency classes, back-to-back writes to the same register (WAW) and a global pipeline hold.
- Sits beside the ID-stage decoder; the decoder supplies operand-use and write information, and this block drives the ID bypass muxes and the pipeline stall.

Parameters:
- AW, 5, register-number width; NREG = 2**AW.
- DEPTH, 4, number of pipeline stages from ID through WB. Stage index 1=EXE, 2=MEM, 3=WB.
- LATW, 2, width of the latency-class field.
- SW, 2, width of the forward select; must hold DEPTH-1.
- CNTW, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- hold  in  1  global pipeline freeze (memory wait)
- id_valid  in  1  ID holds a real instruction
- id_rs  in  AW  source register A
- id_rt  in  AW  source register B
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wr_num  in  AW  destination register
- id_lat  in  LATW  stages after issue until the result can be bypassed (ALU=1, load=2, mul=3)
- fwd_rs  out  SW  0=register file, k=bypass from stage k
- fwd_rt  out  SW  same encoding for rt
- id_stall  out  1  freeze IF/ID, inject bubble into EXE
- busy_mask  out  NREG  bit r set while a write to r is in flight
- stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Reset (asynchronous on rstn=0):
  - All entries invalid.
  - fwd_rs=fwd_rt=0, id_stall=0, busy_mask=0, stall_cnt=0.
  - Reset mid-operation discards all in-flight state.
- Per-register entry: valid, age (SW bits), lat (LATW bits). Register 0 is never tracked; busy_mask[0]=0 always.
- Issue:
  - issue = id_valid & id_wr_en & (id_wr_num!=0) & ~id_stall & ~hold.
  - On issue, the entry for id_wr_num is loaded at the next edge with valid=1, age=1, lat=id_lat.
- Ageing:
  - Each edge with hold=0, every other valid entry increments age.
  - An entry whose age==DEPTH-1 clears to invalid instead of incrementing. WB has written the register file, which is write-first.
  - hold=1 freezes all entries, performs no issue and leaves stall_cnt unchanged.
- Same-cycle events:
  - If an issue targets a register that is also ageing or retiring in that cycle, the issue wins (WAW: newest producer).
  - The older producer's result is never selected afterwards.
- Forward/stall (combinational from registered state and ID inputs):
  - For operand X in {rs, rt}: hit = use_X & entry[X].valid & (X!=0).
  - If hit and age>=lat: fwd_X = age.
  - If hit and age<lat: operand not ready, needs stall.
  - Otherwise fwd_X = 0.
  - id_stall = id_valid & (needs stall on rs | needs stall on rt).
  - When fwd_X is computed with id_stall=1, consumers must ignore it.
- stall_cnt increments on each edge where id_stall=1 and hold=0, and saturates at all-ones.
- Latency:
  - An ALU producer followed by a dependent consumer gives zero stall cycles.
  - A load gives 1 stall cycle.
  - A latency-L producer gives L-1 stall cycles.
  - An id_lat value greater than DEPTH-1 is illegal, and an assertion fires on it.

Decomposition:
- Package hazard_pkg holds:
  - Stage index constants: STG_RF=0, STG_EXE=1, STG_MEM=2, STG_WB=3.
  - Latency-class constants: LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3.
  - The forward-select typedef.
- Sub-module sb_entry holds one register's valid/age/lat with load, advance and retire. It is instantiated NREG-1 times in a generate loop.
- The top level holds:
  - the issue decode;
  - two read-side comparators (rs, rt), each an NREG-to-1 mux of entry state;
  - the stall OR;
  - the stall counter.

Test Plan:
1. ALU chain: issue add $8 (lat 1). Next three cycles ID reads rs=$8 each cycle → fwd_rs = 1, then 2, then 3, with id_stall=0. Fourth cycle → fwd_rs=0 and busy_mask[8]=0.
2. Load-use: issue lw $9 (lat 2), then a consumer with rt=$9 → id_stall=1 for exactly 1 cycle, then fwd_rt=2. stall_cnt=1.
3. WAW: issue add $5, then the next cycle issue lw $5, then a consumer on rs=$5 → 1 stall, then fwd_rs=2 (from the lw, never the add).
4. Register zero and unused operands: issue add $0, then a consumer on $0 → fwd=0, no stall, busy_mask=0. Also a consumer with use_rt=0 on a pending rt → no stall.
5. Hold: lw $4 issued, then hold=1 for 3 cycles → busy_mask[4] stays set, age stays frozen, stall_cnt unchanged. After hold drops, the load-use stall still occurs exactly once.
6. Reset mid-flight: a mul $7 (lat 3) is pending, then rstn is pulsed low asynchronously → all outputs 0 immediately. A subsequent consumer on $7 gets fwd=0 and no stall.
